// File: rtl/sqmux_sel_ctrl.sv
// Sequencer for the SQMUX clock-select cell: gates the downstream clock around every SELECT flip.
// Optional feature: define SQMUX_SEL_PIN_EN to add a synchronized SEL_PIN request source.
module sqmux_sel_ctrl #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8,
  parameter bit RESET_SEL     = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic REQ_VALID,
  input  logic REQ_SEL,
`ifdef SQMUX_SEL_PIN_EN
  input  logic SEL_PIN,
`endif
  output logic REQ_READY,
  output logic SELECT,
  output logic GATE_EN,
  output logic BUSY,
  output logic DONE
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GATE_OFF = 2'd1,
    SWITCH   = 2'd2
  } state_t;

  // A settle time of zero would flip SELECT with the clock still running.
  localparam int              SETTLE   = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             sel_nxt, gate_nxt, done_nxt;
  logic             req_fire;
  logic             req_sel_eff;

  assign REQ_READY = (state == IDLE) && !RST;
  assign BUSY      = (state != IDLE);

`ifdef SQMUX_SEL_PIN_EN
  logic [1:0] pin_sync;
  logic       pin_req;

  always_ff @(posedge CLK) begin
    if (RST) pin_sync <= {2{RESET_SEL}};
    else     pin_sync <= {pin_sync[0], SEL_PIN};
  end

  // The pin only raises a request when the handshake port is quiet.
  assign pin_req     = (state == IDLE) && !REQ_VALID && (pin_sync[1] != SELECT);
  assign req_fire    = (REQ_VALID && REQ_READY) || pin_req;
  assign req_sel_eff = REQ_VALID ? REQ_SEL : pin_sync[1];
`else
  assign req_fire    = REQ_VALID && REQ_READY;
  assign req_sel_eff = REQ_SEL;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      SELECT  <= RESET_SEL;
      GATE_EN <= 1'b1;
      DONE    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      SELECT  <= sel_nxt;
      GATE_EN <= gate_nxt;
      DONE    <= done_nxt;
    end
  end

  // NOTE: default assignment first so no path through the case infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (req_fire && (req_sel_eff != SELECT)) state_nxt = GATE_OFF;
      GATE_OFF: if (cnt == '0) state_nxt = SWITCH;
      SWITCH:   if (cnt == '0) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_nxt  = cnt;
    sel_nxt  = SELECT;
    gate_nxt = GATE_EN;
    done_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_fire) begin
          if (req_sel_eff != SELECT) begin
            gate_nxt = 1'b0;
            cnt_nxt  = CNT_LOAD;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      GATE_OFF: begin
        if (cnt == '0) begin
          sel_nxt = ~SELECT;
          cnt_nxt = CNT_LOAD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      SWITCH: begin
        if (cnt == '0) begin
          gate_nxt = 1'b1;
          done_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: begin
        gate_nxt = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_sqmux_sel_ctrl.sv
// Scoreboard bench for sqmux_sel_ctrl: a timeline model predicts every output per edge,
// and a monitor pops expected completions whenever DONE pulses.
module tb_sqmux_sel_ctrl;

  localparam int S = 4;

  logic CLK = 1'b0;
  logic RST, REQ_VALID, REQ_SEL;
  logic REQ_READY, SELECT, GATE_EN, BUSY, DONE;

  sqmux_sel_ctrl #(
    .SETTLE_CYCLES(S),
    .CNT_W        (8),
    .RESET_SEL    (1'b0)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .REQ_VALID(REQ_VALID),
    .REQ_SEL  (REQ_SEL),
    .REQ_READY(REQ_READY),
    .SELECT   (SELECT),
    .GATE_EN  (GATE_EN),
    .BUSY     (BUSY),
    .DONE     (DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int due;
    bit sel;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Timeline model: the last accepted request, identified by the edge that opened
  // its handshake cycle, fully determines the outputs after any later edge.
  int e_cnt      = 0;
  bit m_valid    = 1'b0;
  bit active     = 1'b0;
  bit acc_switch = 1'b0;
  int acc        = 0;
  bit sel_before = 1'b0;
  bit sel_after  = 1'b0;
  bit acc_flag   = 1'b0;

  function automatic bit m_busy(int x);
    return active && acc_switch && (x >= acc + 1) && (x <= acc + 2 * S);
  endfunction

  function automatic bit m_sel(int x);
    return (active && acc_switch && (x >= acc + S + 1)) ? sel_after : sel_before;
  endfunction

  function automatic bit m_done(int x);
    return active && (x == acc + (acc_switch ? 2 * S + 1 : 1));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, e_cnt, act, exp);
    end
  endtask

  task automatic model_edge();
    bit cur;
    e_cnt++;
    acc_flag = 1'b0;
    if (RST) begin
      m_valid    = 1'b1;
      active     = 1'b0;
      sel_before = 1'b0;
      exp_q.delete();
    end else if (m_valid && REQ_VALID && !m_busy(e_cnt - 1)) begin
      cur        = m_sel(e_cnt - 1);
      acc        = e_cnt - 1;
      acc_switch = (REQ_SEL != cur);
      sel_before = cur;
      sel_after  = REQ_SEL;
      active     = 1'b1;
      acc_flag   = 1'b1;
      exp_q.push_back(exp_t'{due: acc + (acc_switch ? 2 * S + 1 : 1), sel: REQ_SEL});
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_edge();
    #2;
  endtask

  task automatic idle(input int n);
    REQ_VALID = 1'b0;
    repeat (n) cycle();
  endtask

  // Holds the request until the handshake completes; REQ_VALID stays high on return.
  task automatic send(input bit sel);
    int n;
    REQ_VALID = 1'b1;
    REQ_SEL   = sel;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!acc_flag && n < 4 * S + 8);
    if (!acc_flag) check("accept_timeout", n, 0);
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    cycle();
    RST = 1'b0;
  endtask

  // Monitor: compares every output against the timeline and drains the scoreboard on DONE.
  always @(negedge CLK) begin
    int   x;
    exp_t e;
    if (m_valid) begin
      x = e_cnt;
      check("select",    SELECT,    m_sel(x));
      check("gate_en",   GATE_EN,   !m_busy(x));
      check("busy",      BUSY,      m_busy(x));
      check("done",      DONE,      m_done(x));
      check("req_ready", REQ_READY, !RST && !m_busy(x));
      if (DONE === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", DONE, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("done_due", x, e.due);
          check("done_sel", SELECT, e.sel);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST       = 1'b1;
    REQ_VALID = 1'b0;
    REQ_SEL   = 1'b0;
    repeat (2) cycle();
    RST = 1'b0;
    idle(2);

    send(1'b1);                // full 0->1 switch
    idle(2 * S + 3);
    send(1'b1);                // same-value request
    idle(2);
    send(1'b0);                // request held through busy, then back-to-back
    send(1'b1);
    idle(2 * S + 3);
    send(1'b0);                // reset in the middle of a 1->0 switch
    idle(S + 1);
    pulse_reset();
    idle(3);

    for (int i = 0; i < 40; i++) begin
      send(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 2 * S + 4));
      if ($urandom_range(0, 9) == 0) begin
        idle($urandom_range(1, 2 * S));
        pulse_reset();
      end
    end

    idle(2 * S + 4);
    check("scoreboard_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
